// File: rtl/traffic_ctrl_param.sv
// Two-road demand-actuated traffic-light controller with tick-based phase timing.
// Optional pedestrian walk phase enabled by defining TLC_PED_EN.
module traffic_ctrl_param #(
  parameter int CNT_W      = 4,
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 8,
  parameter int YELLOW_LEN = 2,
  parameter int ALLRED_LEN = 1,
  parameter int WALK_LEN   = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       TICK,
  input  logic       SA,
  input  logic       SB,
`ifdef TLC_PED_EN
  input  logic       PED_REQ,
  output logic       WALK,
`endif
  output logic       GA,
  output logic       YA,
  output logic       RA,
  output logic       GB,
  output logic       YB,
  output logic       RB,
  output logic [2:0] PHASE,
  output logic       OCLK
);

  typedef enum logic [2:0] {
    ST_A_GRN  = 3'd0,
    ST_A_YEL  = 3'd1,
    ST_RED_AB = 3'd2,
    ST_B_GRN  = 3'd3,
    ST_B_YEL  = 3'd4,
    ST_RED_BA = 3'd5,
    ST_WALK   = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_LEN - 1);
  localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALLRED_LEN - 1);
  localparam logic [CNT_W-1:0] WALK_M1 = CNT_W'(WALK_LEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic [CNT_W-1:0] t_last;
  logic             is_green;
  logic             ped_go;

`ifdef TLC_PED_EN
  logic ped_pend_q, ped_pend_d;
  logic next_dir_q, next_dir_d;   // 1: walk resumes to B green, 0: to A green
  assign ped_go = ped_pend_q;
`else
  assign ped_go = 1'b0;
`endif

  // Terminal count of the fixed-length phases; greens use their own min/max rule.
  always_comb begin
    t_last = '0;
    case (state_q)
      ST_A_YEL, ST_B_YEL:   t_last = YEL_M1;
      ST_RED_AB, ST_RED_BA: t_last = AR_M1;
      ST_WALK:              t_last = WALK_M1;
      default:              t_last = '0;
    endcase
  end

  assign is_green = (state_q == ST_A_GRN) || (state_q == ST_B_GRN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_A_GRN:
        if (TICK && t_q >= GMIN_M1 && SB && (!SA || t_q >= GMAX_M1)) state_d = ST_A_YEL;
      ST_A_YEL:
        if (TICK && t_q == t_last) state_d = ST_RED_AB;
      ST_RED_AB:
        if (TICK && t_q == t_last) state_d = ped_go ? ST_WALK : ST_B_GRN;
      ST_B_GRN:
        if (TICK && t_q >= GMIN_M1 && SA && (!SB || t_q >= GMAX_M1)) state_d = ST_B_YEL;
      ST_B_YEL:
        if (TICK && t_q == t_last) state_d = ST_RED_BA;
      ST_RED_BA:
        if (TICK && t_q == t_last) state_d = ped_go ? ST_WALK : ST_A_GRN;
`ifdef TLC_PED_EN
      ST_WALK:
        if (TICK && t_q == t_last) state_d = next_dir_q ? ST_B_GRN : ST_A_GRN;
`endif
      default: state_d = ST_A_GRN;
    endcase
  end

  // Timer restarts on any state change and parks at GREEN_MAX-1 while green.
  always_comb begin
    t_d = t_q;
    if (state_d != state_q)
      t_d = '0;
    else if (TICK && !(is_green && t_q >= GMAX_M1))
      t_d = t_q + 1'b1;
  end

`ifdef TLC_PED_EN
  always_comb begin
    next_dir_d = next_dir_q;
    if (state_q == ST_RED_AB && state_d != ST_RED_AB) next_dir_d = 1'b1;
    if (state_q == ST_RED_BA && state_d != ST_RED_BA) next_dir_d = 1'b0;
    ped_pend_d = ped_pend_q;
    if (state_d == ST_WALK && state_q != ST_WALK) ped_pend_d = 1'b0;
    if (PED_REQ) ped_pend_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ped_pend_q <= 1'b0;
      next_dir_q <= 1'b0;
    end else begin
      ped_pend_q <= ped_pend_d;
      next_dir_q <= next_dir_d;
    end
  end

  assign WALK = (state_q == ST_WALK);
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_A_GRN;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  always_comb begin
    {GA, YA, RA, GB, YB, RB} = 6'b001001;
    case (state_q)
      ST_A_GRN: {GA, YA, RA, GB, YB, RB} = 6'b100001;
      ST_A_YEL: {GA, YA, RA, GB, YB, RB} = 6'b010001;
      ST_B_GRN: {GA, YA, RA, GB, YB, RB} = 6'b001100;
      ST_B_YEL: {GA, YA, RA, GB, YB, RB} = 6'b001010;
      default:  {GA, YA, RA, GB, YB, RB} = 6'b001001;
    endcase
  end

  assign PHASE = state_q;
  assign OCLK  = CLK;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Directed bench for traffic_ctrl_param: reset, demand switch, max green, tick gating,
// async reset mid-phase and (with TLC_PED_EN) the pedestrian walk phase.
module tb_traffic_ctrl_param;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       TICK = 1'b1;
  logic       SA = 1'b0;
  logic       SB = 1'b0;
  logic       GA, YA, RA, GB, YB, RB;
  logic [2:0] PHASE;
  logic       OCLK;
  logic       walk_o;
`ifdef TLC_PED_EN
  logic       PED_REQ = 1'b0;
  logic       WALK;
  assign walk_o = WALK;
`else
  assign walk_o = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit tick_div4 = 1'b0;

  traffic_ctrl_param dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .TICK   (TICK),
    .SA     (SA),
    .SB     (SB),
`ifdef TLC_PED_EN
    .PED_REQ(PED_REQ),
    .WALK   (WALK),
`endif
    .GA     (GA),
    .YA     (YA),
    .RA     (RA),
    .GB     (GB),
    .YB     (YB),
    .RB     (RB),
    .PHASE  (PHASE),
    .OCLK   (OCLK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Hand table: {WALK, GA,YA,RA,GB,YB,RB, PHASE} for each phase code.
  function automatic logic [15:0] exp_vec(input int ph);
    logic [6:0] l;
    case (ph)
      0: l = 7'b0100001;
      1: l = 7'b0010001;
      2: l = 7'b0001001;
      3: l = 7'b0001100;
      4: l = 7'b0001010;
      5: l = 7'b0001001;
      6: l = 7'b1001001;
      default: l = 7'b0000000;
    endcase
    return {6'd0, l, 3'(ph)};
  endfunction

  function automatic logic [15:0] obs_vec();
    return {6'd0, walk_o, GA, YA, RA, GB, YB, RB, PHASE};
  endfunction

  // Check n consecutive cycles (outputs before each edge) against one phase.
  task automatic run_expect(input string tag, input int n, input int ph);
    for (int i = 0; i < n; i++) begin
      TICK = tick_div4 ? ((cyc % 4) == 3) : 1'b1;
      chk($sformatf("%s_c%0d", tag, cyc), obs_vec(), exp_vec(ph));
      $display("cyc %0d tick %0b sa %0b sb %0b phase %0d", cyc, TICK, SA, SB, PHASE);
      @(posedge CLK);
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk({tag, "_rst"}, obs_vec(), exp_vec(0));
    @(negedge CLK);
    RST_N = 1'b1;
    cyc = 0;
  endtask

  initial begin
    // 1: reset state and indefinite rest with no demand
    #2;
    chk("t1_rst_t0", obs_vec(), exp_vec(0));
    do_reset("t1");
    run_expect("t1_rest", 50, 0);

    // 2: demand switch A -> B
    SA = 1'b0; SB = 1'b0;
    do_reset("t2");
    SB = 1'b1;
    run_expect("t2_agrn", 4, 0);
    run_expect("t2_ayel", 2, 1);
    run_expect("t2_rab", 1, 2);
    run_expect("t2_bgrn", 1, 3);

    // 3: max green with demand on both roads
    SA = 1'b1; SB = 1'b1;
    do_reset("t3");
    run_expect("t3_agrn", 8, 0);
    run_expect("t3_ayel", 2, 1);
    run_expect("t3_rab", 1, 2);
    run_expect("t3_bgrn", 8, 3);
    run_expect("t3_byel", 2, 4);
    run_expect("t3_rba", 1, 5);
    run_expect("t3_agrn2", 1, 0);

    // 4: tick every 4th cycle stretches every phase by 4x
    SA = 1'b0; SB = 1'b1;
    do_reset("t4");
    tick_div4 = 1'b1;
    run_expect("t4_agrn", 16, 0);
    run_expect("t4_ayel", 8, 1);
    run_expect("t4_rab", 4, 2);
    run_expect("t4_bgrn", 1, 3);
    tick_div4 = 1'b0;
    TICK = 1'b1;

    // 5: asynchronous reset during B yellow, timer restarts from zero
    SA = 1'b1; SB = 1'b1;
    do_reset("t5");
    run_expect("t5_agrn", 8, 0);
    run_expect("t5_ayel", 2, 1);
    run_expect("t5_rab", 1, 2);
    run_expect("t5_bgrn", 8, 3);
    run_expect("t5_byel", 1, 4);
    #2;
    RST_N = 1'b0;
    #1;
    chk("t5_async", obs_vec(), exp_vec(0));
    @(negedge CLK);
    RST_N = 1'b1;
    cyc = 0;
    SA = 1'b0; SB = 1'b1;
    run_expect("t5_agrn2", 4, 0);
    run_expect("t5_ayel2", 2, 1);
    run_expect("t5_rab2", 1, 2);
    run_expect("t5_bgrn2", 1, 3);

`ifdef TLC_PED_EN
    // 6: pedestrian request inserts one walk phase, then B green
    SA = 1'b0; SB = 1'b1;
    do_reset("t6");
    run_expect("t6_agrn", 1, 0);
    PED_REQ = 1'b1;
    run_expect("t6_agrn_req", 1, 0);
    PED_REQ = 1'b0;
    run_expect("t6_agrn2", 2, 0);
    run_expect("t6_ayel", 2, 1);
    run_expect("t6_rab", 1, 2);
    run_expect("t6_walk", 3, 6);
    run_expect("t6_bgrn", 1, 3);
    SA = 1'b1; SB = 1'b0;
    run_expect("t6_bgrn2", 3, 3);
    run_expect("t6_byel", 2, 4);
    run_expect("t6_rba", 1, 5);
    run_expect("t6_agrn3", 3, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
